mac_output_drain: RTL and testbench

Drains the 16-row result array of `mac_16` into the single-bank output SRAM after an accumulation pass. On `start` it snapshots `latch_array_out` (16 rows × 384 bits), so the MAC can begin the next pass at once. It then writes one row per accepted SRAM handshake to consecutive addresses from `base_addr`. It sits between `mac_16` and the output SRAM, opposite the A/B feeder, and produces the row-per-word layout used for golden-output comparison.

---
 rtl/mac_pkg.sv | 17 +
 rtl/row_snapshot.sv | 30 +++
 rtl/mac_output_drain.sv | 90 +++++++++
 tb/tb_mac_output_drain.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared sizing and FSM state encoding for the mac_16 result path.
// The mac_16 output bus width is derived from rows x row width.
package mac_pkg;

  localparam int NUM_ROWS = 16;
  localparam int ROW_W    = 384;
  localparam int ADDR_W   = 11;
  localparam int ARRAY_W  = NUM_ROWS * ROW_W;
  localparam int CNT_W    = $clog2(NUM_ROWS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } drain_state_t;

endpackage

// File: rtl/row_snapshot.sv
// NUM_ROWS x ROW_W capture register loaded in one cycle, read one row at a time.
// Read port is a pure mux of stored rows; cleared to zero on reset.
module row_snapshot
  import mac_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 capture,
  input  logic [ARRAY_W-1:0]   array_in,
  input  logic [CNT_W-1:0]     rd_sel,
  output logic [ROW_W-1:0]     rd_data
);

  logic [ROW_W-1:0] rows [NUM_ROWS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        rows[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < NUM_ROWS; i++) begin
        rows[i] <= array_in[i*ROW_W +: ROW_W];
      end
    end
  end

  assign rd_data = rows[rd_sel];

endmodule

// File: rtl/mac_output_drain.sv
// Snapshots the mac_16 result array on start and writes one row per SRAM handshake.
// First write request the cycle after start; a low ready simply holds the current row.
module mac_output_drain
  import mac_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ARRAY_W-1:0]   latch_array_in,
  output logic                 sram_wr_en,
  output logic [ADDR_W-1:0]    sram_wr_addr,
  output logic [ROW_W-1:0]     sram_wr_data,
  input  logic                 sram_wr_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  drain_state_t         state;
  drain_state_t         state_nxt;
  logic [CNT_W-1:0]     row_cnt;
  logic [ADDR_W-1:0]    base_q;
  logic                 overrun_q;
  logic                 accept;
  logic                 wr_fire;
  logic                 last_row;

  assign accept   = start && (state == ST_IDLE);
  assign wr_fire  = (state == ST_DRAIN) && sram_wr_ready;
  assign last_row = (row_cnt == CNT_W'(NUM_ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_DRAIN;
      ST_DRAIN: if (wr_fire && last_row) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= '0;
      base_q  <= '0;
    end else if (accept) begin
      row_cnt <= '0;
      base_q  <= base_addr;
    end else if (wr_fire) begin
      row_cnt <= row_cnt + CNT_W'(1);
    end
  end

  // A start seen while busy (including the done cycle) is dropped but remembered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (accept) begin
      overrun_q <= 1'b0;
    end else if (start) begin
      overrun_q <= 1'b1;
    end
  end

  row_snapshot u_row_snapshot (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (accept),
    .array_in (latch_array_in),
    .rd_sel   (row_cnt),
    .rd_data  (sram_wr_data)
  );

  // Address adder wraps naturally at 2^ADDR_W; forced to 0 outside DRAIN.
  assign sram_wr_en   = (state == ST_DRAIN);
  assign sram_wr_addr = sram_wr_en ? (base_q + ADDR_W'(row_cnt)) : '0;
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_mac_output_drain.sv
// Scoreboard bench for mac_output_drain: expected rows queued at start, popped on each handshake.
module tb_mac_output_drain;
  import mac_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [ADDR_W-1:0]   base_addr;
  logic [ARRAY_W-1:0]  latch_array_in;
  logic                sram_wr_en;
  logic [ADDR_W-1:0]   sram_wr_addr;
  logic [ROW_W-1:0]    sram_wr_data;
  logic                sram_wr_ready;
  logic                busy;
  logic                done;
  logic                overrun;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ROW_W-1:0]  data;
  } exp_t;

  exp_t sb [$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mac_output_drain dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .base_addr      (base_addr),
    .latch_array_in (latch_array_in),
    .sram_wr_en     (sram_wr_en),
    .sram_wr_addr   (sram_wr_addr),
    .sram_wr_data   (sram_wr_data),
    .sram_wr_ready  (sram_wr_ready),
    .busy           (busy),
    .done           (done),
    .overrun        (overrun)
  );

  task automatic check_val(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_pattern(input int kind);
    for (int i = 0; i < NUM_ROWS; i++) begin
      logic [7:0]       b;
      logic [ROW_W-1:0] row;
      b = 8'(i);
      if (kind == 0) begin
        row = {48{b}};
      end else begin
        for (int j = 0; j < ROW_W / 32; j++) row[j*32 +: 32] = $urandom;
      end
      latch_array_in[i*ROW_W +: ROW_W] = row;
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 with start dropped.
  task automatic do_start(input logic [ADDR_W-1:0] b);
    for (int i = 0; i < NUM_ROWS; i++) begin
      exp_t e;
      e.addr = b + ADDR_W'(i);
      e.data = latch_array_in[i*ROW_W +: ROW_W];
      sb.push_back(e);
    end
    start     = 1'b1;
    base_addr = b;
    @(negedge clk);
    start     = 1'b0;
    base_addr = '0;
  endtask

  task automatic drain(input int stall_mod, input bit corrupt, input bit do_ovr, input int abort_at);
    int               cyc;
    int               writes;
    int               stalls;
    bit               held;
    bit               fin;
    bit               rdy;
    logic [ADDR_W-1:0] h_addr;
    logic [ROW_W-1:0]  h_data;
    exp_t             e;
    cyc = 1; writes = 0; stalls = 0; held = 0; fin = 0;
    h_addr = '0; h_data = '0;
    while (cyc <= 80 && !fin) begin
      if (abort_at > 0 && writes == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_val("abort_wr_en", sram_wr_en, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_addr", sram_wr_addr, 0);
        check_val("abort_data", sram_wr_data, 0);
        sb.delete();
        fin = 1;
      end else begin
        check_val("busy", busy, 1);
        check_val("wr_en", sram_wr_en, (writes < NUM_ROWS) ? 1 : 0);
        check_val("done", done, (writes == NUM_ROWS) ? 1 : 0);
        check_val("overrun", overrun, (do_ovr && cyc > 5) ? 1 : 0);
        if (held) begin
          check_val("stall_addr", sram_wr_addr, h_addr);
          check_val("stall_data", sram_wr_data, h_data);
        end
        if (writes == NUM_ROWS) begin
          check_val("done_cycle", cyc, 17 + stalls);
          if (do_ovr) begin
            start     = 1'b1;
            base_addr = 11'h123;
          end
          fin = 1;
        end else begin
          rdy = !(stall_mod > 0 && (cyc % stall_mod) == 0);
          sram_wr_ready = rdy;
          if (rdy) begin
            if (sb.size() == 0) begin
              check_val("sb_empty", 1, 0);
            end else begin
              e = sb.pop_front();
              check_val("wr_addr", sram_wr_addr, e.addr);
              check_val("wr_data", sram_wr_data, e.data);
            end
            writes++;
            held = 0;
          end else begin
            stalls++;
            held   = 1;
            h_addr = sram_wr_addr;
            h_data = sram_wr_data;
          end
        end
        if (corrupt && cyc == 1) latch_array_in = '1;
        if (do_ovr && cyc == 5) begin
          start          = 1'b1;
          base_addr      = 11'h555;
          latch_array_in = ~latch_array_in;
        end
        if (do_ovr && cyc == 6) begin
          start     = 1'b0;
          base_addr = '0;
        end
        if (!fin) begin
          @(negedge clk);
          cyc++;
        end
      end
    end
    if (!fin) check_val("drain_timeout", 0, 1);
    sram_wr_ready = 1'b1;
  endtask

  task automatic post_idle(input bit exp_ovr);
    @(negedge clk);
    start     = 1'b0;
    base_addr = '0;
    check_val("idle_busy", busy, 0);
    check_val("idle_done", done, 0);
    check_val("idle_wr_en", sram_wr_en, 0);
    check_val("idle_overrun", overrun, exp_ovr);
    check_val("sb_left", sb.size(), 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    base_addr      = '0;
    latch_array_in = '0;
    sram_wr_ready  = 1'b1;
    load_pattern(1);
    #3;
    check_val("rst_wr_en", sram_wr_en, 0);
    check_val("rst_addr", sram_wr_addr, 0);
    check_val("rst_data", sram_wr_data, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_overrun", overrun, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check_val("quiet_wr_en", sram_wr_en, 0);
      check_val("quiet_busy", busy, 0);
    end

    // basic drain, row i = {48{i}}
    load_pattern(0);
    do_start(11'd0);
    drain(0, 0, 0, 0);
    post_idle(0);

    // stall every third cycle, input array trashed after capture
    load_pattern(1);
    do_start(11'd100);
    drain(3, 1, 0, 0);
    post_idle(0);

    // address wrap
    load_pattern(1);
    do_start(11'd2040);
    drain(0, 0, 0, 0);
    post_idle(0);

    // overrun during drain and in the done cycle
    load_pattern(0);
    do_start(11'd7);
    drain(0, 0, 1, 0);
    post_idle(1);
    repeat (3) begin
      @(negedge clk);
      check_val("ovr_hold", overrun, 1);
      check_val("ovr_no_restart", busy, 0);
    end

    // reset mid-drain, then a fresh drain
    load_pattern(1);
    do_start(11'd0);
    drain(0, 0, 0, 8);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_val("post_rst_wr_en", sram_wr_en, 0);
      check_val("post_rst_done", done, 0);
      check_val("post_rst_busy", busy, 0);
    end
    load_pattern(0);
    do_start(11'd500);
    drain(0, 0, 0, 0);
    post_idle(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
